// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence detector and its event monitor.
// Holds state encodings and the saturating increment used by all counters.
package seq_pkg;

  typedef enum logic {
    MON_IDLE  = 1'b0,
    MON_COUNT = 1'b1
  } mon_state_e;

  typedef enum logic [1:0] {
    DET_IDLE = 2'd0,
    DET_S1   = 2'd1,
    DET_S10  = 2'd2,
    DET_S101 = 2'd3
  } det_state_e;

  // Adds inc to val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    sat_inc = (inc && (val < max_val)) ? (val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/seq_report_reg.sv
// Depth-1 valid/ready report holding register; a new report overwrites an
// unaccepted one and flags the loss through overrun.
module seq_report_reg
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overrun_o
);

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovr_q, ovr_d;

  // Overrun only when the held report is still pending at the load edge.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    if (load_i) begin
      valid_d = 1'b1;
      count_d = count_i;
      ovr_d   = valid_q & ~ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o   = valid_q;
  assign count_o   = count_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/seq_event_monitor.sv
// Windowed rate monitor for detector strobes: counts events per window,
// reports each window through a valid/ready port, keeps a saturating total.
module seq_event_monitor
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16,
  parameter int unsigned TOT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_seen,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIN_W-1:0] win_len,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_overrun,
  output logic [TOT_W-1:0] total_count,
  output logic             busy
);

  mon_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_left_q, win_left_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [WIN_W-1:0] win_reload;
  logic             rpt_load;
  logic [CNT_W-1:0] rpt_value;

  // A zero length behaves as a one-cycle window.
  assign win_reload = (win_len == '0) ? '0 : (win_len - WIN_W'(1));

  always_comb begin
    state_d    = state_q;
    win_left_d = win_left_q;
    win_cnt_d  = win_cnt_q;
    total_d    = total_q;
    rpt_load   = 1'b0;
    rpt_value  = '0;
    unique case (state_q)
      MON_IDLE: begin
        if (enable) begin
          state_d    = MON_COUNT;
          win_left_d = win_reload;
          win_cnt_d  = '0;
        end
      end
      MON_COUNT: begin
        total_d = TOT_W'(sat_inc(32'(total_q), seq_seen, TOT_W));
        if (win_left_q != '0) begin
          win_left_d = win_left_q - WIN_W'(1);
          win_cnt_d  = CNT_W'(sat_inc(32'(win_cnt_q), seq_seen, CNT_W));
        end else begin
          // Last window cycle: its own event is part of the report.
          rpt_load  = 1'b1;
          rpt_value = CNT_W'(sat_inc(32'(win_cnt_q), seq_seen, CNT_W));
          win_cnt_d = '0;
          if (enable) begin
            win_left_d = win_reload;
          end else begin
            state_d = MON_IDLE;
          end
        end
      end
      default: state_d = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MON_IDLE;
      win_left_q <= '0;
      win_cnt_q  <= '0;
      total_q    <= '0;
    end else if (clear) begin
      state_q    <= MON_IDLE;
      win_left_q <= '0;
      win_cnt_q  <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      win_left_q <= win_left_d;
      win_cnt_q  <= win_cnt_d;
      total_q    <= total_d;
    end
  end

  seq_report_reg #(
    .CNT_W(CNT_W)
  ) u_report (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load_i   (rpt_load),
    .count_i  (rpt_value),
    .ready_i  (rpt_ready),
    .valid_o  (rpt_valid),
    .count_o  (rpt_count),
    .overrun_o(rpt_overrun)
  );

  assign total_count = total_q;
  assign busy        = (state_q == MON_COUNT);

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench for seq_event_monitor: directed windows with expected reports queued
// on the window's last cycle and compared when they become due.
module tb_seq_event_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned TOT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             seq_seen;
  logic             enable;
  logic             clear;
  logic [WIN_W-1:0] win_len;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_overrun;
  logic [TOT_W-1:0] total_count;
  logic             busy;

  typedef struct {
    int cnt;
    bit ovr;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_total = 0;
  bit   ev_bits[1:512];

  seq_event_monitor #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W),
    .TOT_W(TOT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seq_seen   (seq_seen),
    .enable     (enable),
    .clear      (clear),
    .win_len    (win_len),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_count  (rpt_count),
    .rpt_overrun(rpt_overrun),
    .total_count(total_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    for (int i = 1; i <= 512; i++) ev_bits[i] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(rpt_valid), 0);
    chk({tag, "_count"}, 32'(rpt_count), 0);
    chk({tag, "_ovr"}, 32'(rpt_overrun), 0);
    chk({tag, "_total"}, 32'(total_count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Drives one window of len COUNT cycles from ev_bits; enable drops from drop_at on.
  task automatic run_win(input int len, input bit exp_ovr, input int drop_at);
    int n;
    n = 0;
    for (int k = 1; k <= len; k++) begin
      seq_seen = ev_bits[k];
      if (ev_bits[k]) n++;
      if (drop_at != 0 && k >= drop_at) enable = 1'b0;
      if (k == len) sb.push_back('{cnt: (n > 255) ? 255 : n, ovr: exp_ovr, due: cyc + 1});
      step();
    end
    seq_seen = 1'b0;
    exp_total += n;
  endtask

  // Scoreboard checker: a report must be visible in the cycle it becomes due.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rpt_valid", 32'(rpt_valid), 1);
      chk("rpt_count", 32'(rpt_count), 32'(e.cnt));
      chk("rpt_overrun", 32'(rpt_overrun), 32'(e.ovr));
    end
  end

  initial begin
    bit [5:0] pat;
    reset     = 1'b1;
    seq_seen  = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    win_len   = '0;
    rpt_ready = 1'b0;
    step();
    step();
    chk_all_zero("por");
    reset = 1'b0;
    step();

    // 8-cycle window, events on cycles 2,5,8, consumer always ready
    rpt_ready = 1'b1;
    win_len   = WIN_W'(8);
    enable    = 1'b1;
    step();
    chk("a_busy", 32'(busy), 1);
    clr_ev();
    ev_bits[2] = 1'b1; ev_bits[5] = 1'b1; ev_bits[8] = 1'b1;
    run_win(8, 1'b0, 0);
    chk("a_total", 32'(total_count), 3);
    chk("a_busy_nogap", 32'(busy), 1);

    // contiguous second window, enable dropped at cycle 3 of 8
    clr_ev();
    ev_bits[1] = 1'b1;
    run_win(8, 1'b0, 3);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_total", 32'(total_count), 32'(exp_total));
    seq_seen = 1'b1;
    step(); step(); step();
    seq_seen = 1'b0;
    chk("idle_total", 32'(total_count), 32'(exp_total));
    chk("idle_valid", 32'(rpt_valid), 0);

    // overwrite with consumer stalled
    rpt_ready = 1'b0;
    win_len   = WIN_W'(4);
    enable    = 1'b1;
    step();
    clr_ev();
    ev_bits[2] = 1'b1;
    run_win(4, 1'b0, 0);
    clr_ev();
    ev_bits[1] = 1'b1; ev_bits[3] = 1'b1;
    run_win(4, 1'b1, 4);
    step(); step();
    chk("hold_valid", 32'(rpt_valid), 1);
    chk("hold_count", 32'(rpt_count), 2);
    chk("hold_ovr", 32'(rpt_overrun), 1);
    chk("hold_busy", 32'(busy), 0);
    rpt_ready = 1'b1;
    step();
    chk("accept_valid", 32'(rpt_valid), 0);
    chk("b_total", 32'(total_count), 32'(exp_total));

    // clear from idle
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_total = 0;
    chk_all_zero("clr1");

    // 300-cycle window saturates the window count but not the total
    win_len = WIN_W'(300);
    enable  = 1'b1;
    step();
    clr_ev();
    for (int i = 1; i <= 300; i++) ev_bits[i] = 1'b1;
    run_win(300, 1'b0, 300);
    chk("sat_total", 32'(total_count), 300);
    chk("sat_busy", 32'(busy), 0);
    step();

    // zero length: one report per cycle, accepted and reloaded on the same edge
    win_len = '0;
    enable  = 1'b1;
    step();
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      clr_ev();
      ev_bits[1] = pat[i];
      run_win(1, 1'b0, (i == 5) ? 1 : 0);
    end
    chk("w0_total", 32'(total_count), 32'(exp_total));
    chk("w0_pend", 32'(rpt_valid), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_total = 0;
    chk_all_zero("clr2");

    // asynchronous reset while counting with a pending report
    rpt_ready = 1'b0;
    win_len   = WIN_W'(2);
    enable    = 1'b1;
    step();
    clr_ev();
    ev_bits[1] = 1'b1;
    run_win(2, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk_all_zero("arst");
    enable = 1'b0;
    reset  = 1'b0;
    step();
    chk_all_zero("post_rst");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
